// File: rtl/image_rom_arbiter.sv
// Shares the input image ROM read port between the VGA scan reader and the Sobel window fetcher.
// VGA has priority; a starvation counter forces a Sobel win after MAX_WAIT denied cycles.
`timescale 1ns/1ps
module image_rom_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 4,
  parameter int MISS_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_miss,
  output logic [MISS_W-1:0] miss_count,
  input  logic              sob_req,
  input  logic [ADDR_W-1:0] sob_addr,
  output logic              sob_gnt,
  output logic              sob_valid,
  output logic [DATA_W-1:0] sob_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0]  wait_cnt;
  logic               sob_win;
  logic               vga_win;
  logic               vga_deny;
  logic               grant;
  logic [ROM_LAT-1:0] tag_vld;
  logic [ROM_LAT-1:0] tag_sob;

  // Grants are suppressed while reset is asserted so sob_gnt drops immediately.
  always_comb begin
    sob_win  = 1'b0;
    vga_win  = 1'b0;
    vga_deny = 1'b0;
    rom_addr = '0;
    if (!rst) begin
      sob_win  = sob_req && (!vga_req || (wait_cnt == WAIT_MAX));
      vga_win  = vga_req && !sob_win;
      vga_deny = vga_req && sob_win;
    end
    grant   = sob_win || vga_win;
    sob_gnt = sob_win;
    rom_en  = grant;
    if (sob_win) begin
      rom_addr = sob_addr;
    end else if (vga_win) begin
      rom_addr = vga_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (sob_req && !sob_win) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Tag pipeline tracks which requester owns each in-flight ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_sob <= '0;
    end else begin
      tag_vld[0] <= grant;
      tag_sob[0] <= sob_win;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_sob[i] <= tag_sob[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_valid <= 1'b0;
      vga_data  <= '0;
      sob_valid <= 1'b0;
      sob_data  <= '0;
    end else begin
      vga_valid <= 1'b0;
      sob_valid <= 1'b0;
      if (tag_vld[ROM_LAT-1]) begin
        if (tag_sob[ROM_LAT-1]) begin
          sob_valid <= 1'b1;
          sob_data  <= rom_data;
        end else begin
          vga_valid <= 1'b1;
          vga_data  <= rom_data;
        end
      end
    end
  end

  // Denied VGA requests are dropped; only the miss is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_miss   <= 1'b0;
      miss_count <= '0;
    end else begin
      vga_miss <= vga_deny;
      if (vga_deny && (miss_count != '1)) begin
        miss_count <= miss_count + MISS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Scoreboard bench for image_rom_arbiter: directed requests push expected returns,
// a negedge monitor pops and compares them against the DUT's valid strobes.
`timescale 1ns/1ps
module tb_image_rom_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int ROM_LAT  = 1;
  localparam int MAX_WAIT = 4;
  localparam int MISS_W   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vga_req = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_data;
  logic              vga_miss;
  logic [MISS_W-1:0] miss_count;
  logic              sob_req = 1'b0;
  logic [ADDR_W-1:0] sob_addr = '0;
  logic              sob_gnt;
  logic              sob_valid;
  logic [DATA_W-1:0] sob_data;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [MISS_W-1:0] exp_miss = '0;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] due;
  } exp_t;

  exp_t vga_q[$];
  exp_t sob_q[$];

  image_rom_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT),
    .MAX_WAIT(MAX_WAIT), .MISS_W(MISS_W)
  ) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid),
    .vga_data(vga_data), .vga_miss(vga_miss), .miss_count(miss_count),
    .sob_req(sob_req), .sob_addr(sob_addr), .sob_gnt(sob_gnt),
    .sob_valid(sob_valid), .sob_data(sob_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: each location holds addr[7:0], ROM_LAT edges of latency.
  logic [7:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_en ? rom_addr[7:0] : 8'h00;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  // Sobel must hold its address while a request is pending.
  logic              sob_pend;
  logic [ADDR_W-1:0] sob_addr_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sob_pend   <= 1'b0;
      sob_addr_q <= '0;
    end else begin
      if (sob_pend) assert (sob_addr == sob_addr_q) else $error("[TB] sob_addr changed while pending");
      sob_pend   <= sob_req && !sob_gnt;
      sob_addr_q <= sob_addr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // win: 0 = no grant, 1 = VGA wins, 2 = Sobel wins (hand-computed per vector).
  task automatic applyStimulus(input logic vr, input logic [ADDR_W-1:0] va,
                               input logic sr, input logic [ADDR_W-1:0] sa,
                               input int win, input bit expect_ret);
    exp_t e;
    logic [ADDR_W-1:0] exp_addr;
    @(negedge clk);
    vga_req = vr; vga_addr = va; sob_req = sr; sob_addr = sa;
    #1;
    exp_addr = (win == 1) ? va : (win == 2) ? sa : '0;
    checkOutput("rom_en", 32'(rom_en), 32'(win != 0));
    checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr));
    checkOutput("sob_gnt", 32'(sob_gnt), 32'(win == 2));
    if (expect_ret && win != 0) begin
      e.data = exp_addr[7:0];
      e.due  = 32'(cyc + ROM_LAT + 1);
      if (win == 1) vga_q.push_back(e);
      else          sob_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (vr && win == 2 && exp_miss != '1) exp_miss = exp_miss + 1'b1;
    checkOutput("vga_miss", 32'(vga_miss), 32'(vr && win == 2));
    checkOutput("miss_count", 32'(miss_count), 32'(exp_miss));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 0, 1'b1);
  endtask

  // Monitor: every valid strobe must match the head of its owner's queue, on time.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (vga_valid) begin
        if (vga_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL vga_unexpected: got vga_valid=1 data=0x%0h expected no valid", vga_data);
        end else begin
          e = vga_q.pop_front();
          checkOutput("vga_data", 32'(vga_data), 32'(e.data));
          checkOutput("vga_latency", 32'(cyc), e.due);
        end
      end
      if (sob_valid) begin
        if (sob_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL sob_unexpected: got sob_valid=1 data=0x%0h expected no valid", sob_data);
        end else begin
          e = sob_q.pop_front();
          checkOutput("sob_data", 32'(sob_data), 32'(e.data));
          checkOutput("sob_latency", 32'(cyc), e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_vga_valid", 32'(vga_valid), 0);
    checkOutput("rst_sob_valid", 32'(sob_valid), 0);
    checkOutput("rst_vga_data", 32'(vga_data), 0);
    checkOutput("rst_sob_data", 32'(sob_data), 0);
    checkOutput("rst_miss_count", 32'(miss_count), 0);
    checkOutput("rst_rom_en", 32'(rom_en), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single VGA read
    applyStimulus(1'b1, 14'h0005, 1'b0, '0, 1, 1'b1);
    idle(3);

    // Back-to-back Sobel reads
    applyStimulus(1'b0, '0, 1'b1, 14'h0081, 2, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 14'h0082, 2, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 14'h0083, 2, 1'b1);
    idle(3);

    // Interleaved owners
    applyStimulus(1'b1, 14'h0010, 1'b0, '0, 1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 14'h0020, 2, 1'b1);
    applyStimulus(1'b1, 14'h0030, 1'b0, '0, 1, 1'b1);
    idle(3);

    // Contention: VGA wins MAX_WAIT cycles, Sobel the next; 19 rounds saturate miss_count
    for (int r = 0; r < 19; r++) begin
      for (int k = 0; k <= MAX_WAIT; k++) begin
        applyStimulus(1'b1, ADDR_W'(14'h0150 + 5 * r + k), 1'b1, ADDR_W'(14'h02A0 + r),
                      (k == MAX_WAIT) ? 2 : 1, 1'b1);
      end
      if (r == 0) checkOutput("miss_after_round1", 32'(miss_count), 1);
    end
    idle(3);
    checkOutput("miss_saturated", 32'(miss_count), 32'hF);

    // Reset one cycle after a grant: the read must never return
    applyStimulus(1'b1, 14'h0040, 1'b0, '0, 1, 1'b0);
    @(negedge clk);
    rst = 1'b1; vga_req = 1'b0; sob_req = 1'b1; sob_addr = 14'h0041;
    #1;
    checkOutput("rst_sob_gnt", 32'(sob_gnt), 0);
    checkOutput("rst_rom_en2", 32'(rom_en), 0);
    checkOutput("rst_vga_valid2", 32'(vga_valid), 0);
    checkOutput("rst_vga_data2", 32'(vga_data), 0);
    checkOutput("rst_sob_data2", 32'(sob_data), 0);
    checkOutput("rst_miss_count2", 32'(miss_count), 0);
    checkOutput("rst_vga_miss2", 32'(vga_miss), 0);
    repeat (2) @(negedge clk);
    sob_req = 1'b0;
    rst = 1'b0;
    exp_miss = '0;
    idle(4);

    checkOutput("vga_q_drained", 32'(vga_q.size()), 0);
    checkOutput("sob_q_drained", 32'(sob_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_rom_arbiter.md
Name: image_rom_arbiter

Overview:
Shares the single read port of the 128x128 8-bit input image ROM between two requesters: the VGA scan reader (real-time display) and the Sobel datapath window fetcher (bulk 3x3 neighbourhood reads). It sits between both requesters and the ROM and grants at most one read per cycle. VGA has priority, and a starvation guard guarantees the Sobel side forward progress. Each requester gets its own read data and valid strobe, returned in issue order.

Parameters:
ADDR_W, 14, ROM address width ({y[6:0], x[6:0]})
DATA_W, 8, pixel width
ROM_LAT, 1, ROM read latency in cycles (clock edges from rom_en to valid rom_data); legal range 1..3
MAX_WAIT, 4, consecutive denied Sobel cycles before Sobel is forced to win; legal range 1..15
MISS_W, 16, width of the VGA miss counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
vga_req  in  1  VGA wants a pixel this cycle (not held; one-shot per pixel)
vga_addr  in  ADDR_W  VGA read address, valid with vga_req
vga_valid  out  1  registered; vga_data valid this cycle
vga_data  out  DATA_W  registered pixel for VGA
vga_miss  out  1  registered 1-cycle pulse; a VGA request was denied
miss_count  out  MISS_W  saturating count of denied VGA requests
sob_req  in  1  Sobel read request; held until sob_gnt
sob_addr  in  ADDR_W  Sobel read address; held stable while sob_req=1 and sob_gnt=0
sob_gnt  out  1  combinational; Sobel request accepted this cycle
sob_valid  out  1  registered; sob_data valid this cycle
sob_data  out  DATA_W  registered pixel for Sobel
rom_en  out  1  combinational ROM read enable
rom_addr  out  ADDR_W  combinational ROM address
rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_en

Behaviour:
- Reset values: vga_valid=0, vga_data=0, vga_miss=0, miss_count=0, sob_valid=0, sob_data=0, starvation counter=0, tag pipeline cleared. Combinational outputs go to 0 when no request is present.
- Arbitration, evaluated each cycle from the current inputs and the registered starvation counter wait_cnt:
  - vga_req only: VGA wins.
  - sob_req only: Sobel wins and sob_gnt=1.
  - Both requesting, wait_cnt<MAX_WAIT: VGA wins, Sobel is denied.
  - Both requesting, wait_cnt==MAX_WAIT: Sobel wins, VGA is denied.
  - Neither requesting: rom_en=0, rom_addr=0.
- Grant: rom_en=1 and rom_addr = the winner's address. sob_gnt=1 only when Sobel wins.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when sob_req=1 and sob_gnt=0.
  - Cleared when sob_gnt=1 or sob_req=0.
- Tag pipeline: ROM_LAT stages of {valid, owner}. Stage 0 is loaded with the grant this cycle.
- Return path: when the final stage is valid, rom_data is registered into the owner's *_data and the owner's *_valid is pulsed for 1 cycle. The non-owner's data holds its value and its valid is 0.
- Total latency is ROM_LAT+1 cycles from grant to *_valid (ROM_LAT=1: grant in cycle N, valid in N+2).
- Throughput: one read per cycle. Back-to-back grants to either requester produce back-to-back valids in order.
- VGA denial: vga_miss pulses in the next cycle. miss_count increments and saturates at all-ones. The denied VGA request is dropped, not retried.
- Sobel protocol violation (sob_addr changes while pending) is undefined; the bench flags it with an assertion.
- Async reset mid-operation clears the tag pipeline, so in-flight reads never produce valids. sob_gnt drops as soon as reset asserts.

Test Plan:
- Reset, then vga_req only at addr 0x0005 (ROM holds addr[7:0]) -> rom_en=1, rom_addr=0x0005 in the same cycle; vga_valid=1 with vga_data=0x05 two cycles later; sob_valid stays 0.
- sob_req only, addrs 0x0081,0x0082,0x0083 issued back-to-back -> sob_gnt=1 each cycle; sob_valid on 3 consecutive cycles with data 0x81,0x82,0x83.
- Continuous vga_req and sob_req, MAX_WAIT=4 -> VGA wins 4 cycles, Sobel wins the 5th; vga_miss pulses once; miss_count=1; pattern repeats every 5 cycles.
- Interleaved grants VGA,SOB,VGA at addrs 0x10,0x20,0x30 -> returns routed correctly: vga 0x10, sob 0x20, vga 0x30, on consecutive cycles with no cross-delivery.
- Assert rst one cycle after a grant -> no *_valid ever appears for that read; all outputs read 0 after reset.
- Force 2^MISS_W+3 VGA denials (MISS_W=4 build) -> miss_count saturates at 0xF.
